fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch.sv | 128 ++++++++++++
 tb/tb_fetch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, the fetch FSM state encoding, the
// default reset PC and the sequential PC increment helper.
package cpu_pkg;

    localparam logic [31:0] START_ADDR_DEFAULT = 32'h0000_0000;
    localparam int          IF_ID_W            = 64;  // {pc, inst}
    localparam int          JBR_W              = 33;  // {taken, target}

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DONE = 2'd2
    } fetch_state_t;

    // Sequential PC step; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage.
// Holds the PC, drives it to a synchronous instruction ROM, waits ROM_LAT
// cycles and captures {pc, inst} for decode. Taken branches reported by
// decode are remembered until the next PC advance request.
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   IF_valid     - fetch stage enabled by the control FSM (level)
//   next_fetch   - pulse: advance PC (ignored while waiting on the ROM)
//   ID_over      - decode complete, jbr_bus valid
//   jbr_bus      - {taken, target[31:0]}
//   inst_addr    - ROM address (the PC register)
//   inst         - ROM read data
//   IF_over      - pulse: instruction captured
//   IF_ID_bus    - {pc_r, inst_r}, stable between captures
//   IF_pc/IF_inst- display copies of the captured pc and instruction
module fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] START_ADDR = START_ADDR_DEFAULT,
    parameter int          ROM_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 IF_valid,
    input  logic                 next_fetch,
    input  logic                 ID_over,
    input  logic [JBR_W-1:0]     jbr_bus,
    output logic [31:0]          inst_addr,
    input  logic [31:0]          inst,
    output logic                 IF_over,
    output logic [IF_ID_W-1:0]   IF_ID_bus,
    output logic [31:0]          IF_pc,
    output logic [31:0]          IF_inst
);

    // Counter preload: WAIT lasts ROM_LAT cycles including the capture cycle.
    localparam logic [2:0] LAT_LOAD = 3'(ROM_LAT - 1);

    fetch_state_t state_r;
    logic [2:0]   cnt_r;
    logic [31:0]  fetch_pc_r;
    logic [31:0]  pc_r;
    logic [31:0]  inst_r;
    logic         if_over_r;
    logic         br_pending_r;
    logic [31:0]  br_target_r;

    logic         accept_s;
    logic         taken_s;
    logic [31:0]  next_pc_s;

    // Advance requests and branch notifications decoded from the inputs.
    always_comb begin
        accept_s = next_fetch && (state_r != FS_WAIT);
        taken_s  = ID_over && jbr_bus[32];
        if (taken_s) begin
            // A branch arriving with the advance request wins directly.
            next_pc_s = jbr_bus[31:0];
        end else if (br_pending_r) begin
            next_pc_s = br_target_r;
        end else begin
            next_pc_s = pc_inc(fetch_pc_r);
        end
    end

    // Fetch FSM: ROM latency countdown, capture and the IF_over pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= FS_IDLE;
            cnt_r     <= 3'd0;
            pc_r      <= 32'h0000_0000;
            inst_r    <= 32'h0000_0000;
            if_over_r <= 1'b0;
        end else begin
            if_over_r <= 1'b0;
            case (state_r)
                FS_IDLE: begin
                    if (IF_valid) begin
                        state_r <= FS_WAIT;
                        cnt_r   <= LAT_LOAD;
                    end
                end
                FS_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        inst_r    <= inst;
                        pc_r      <= fetch_pc_r;
                        if_over_r <= 1'b1;
                        state_r   <= FS_DONE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                FS_DONE: begin
                    if (!IF_valid) begin
                        state_r <= FS_IDLE;
                    end
                end
                default: begin
                    state_r <= FS_IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    // PC register and the pending-branch record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r   <= START_ADDR;
            br_pending_r <= 1'b0;
            br_target_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            fetch_pc_r   <= next_pc_s;
            br_pending_r <= 1'b0;
        end else if (taken_s) begin
            br_pending_r <= 1'b1;
            br_target_r  <= jbr_bus[31:0];
        end
    end

    assign inst_addr = fetch_pc_r;
    assign IF_over   = if_over_r;
    assign IF_ID_bus = {pc_r, inst_r};
    assign IF_pc     = pc_r;
    assign IF_inst   = inst_r;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage. Instance a: ROM_LAT=1, START_ADDR=0.
// Instance b: ROM_LAT=4, START_ADDR=0x1000. Both see the same control
// inputs but have separate resets; b is held in reset while a is exercised.
module tb_fetch;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               reset_a = 1'b1;
    logic               reset_b = 1'b1;
    logic               if_valid = 1'b0;
    logic               next_fetch = 1'b0;
    logic               id_over = 1'b0;
    logic [JBR_W-1:0]   jbr_bus = 33'd0;

    logic [31:0]        a_addr, a_inst, a_pc, a_iinst;
    logic               a_over;
    logic [IF_ID_W-1:0] a_bus;
    logic [31:0]        b_addr, b_inst, b_pc, b_iinst;
    logic               b_over;
    logic [IF_ID_W-1:0] b_bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Synchronous ROM contents as a simple address hash.
    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) + 32'h0000_0011;
    endfunction

    // One-cycle synchronous ROM per instance.
    always_ff @(posedge clk) begin
        a_inst <= rom_f(a_addr);
        b_inst <= rom_f(b_addr);
    end

    fetch #(.START_ADDR(32'h0000_0000), .ROM_LAT(1)) dut_a (
        .clk(clk), .reset(reset_a), .IF_valid(if_valid), .next_fetch(next_fetch),
        .ID_over(id_over), .jbr_bus(jbr_bus), .inst_addr(a_addr), .inst(a_inst),
        .IF_over(a_over), .IF_ID_bus(a_bus), .IF_pc(a_pc), .IF_inst(a_iinst)
    );

    fetch #(.START_ADDR(32'h0000_1000), .ROM_LAT(4)) dut_b (
        .clk(clk), .reset(reset_b), .IF_valid(if_valid), .next_fetch(next_fetch),
        .ID_over(id_over), .jbr_bus(jbr_bus), .inst_addr(b_addr), .inst(b_inst),
        .IF_over(b_over), .IF_ID_bus(b_bus), .IF_pc(b_pc), .IF_inst(b_iinst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        step(); step();
        chk("rst_a_addr", 64'(a_addr), 64'h0);
        chk("rst_a_over", 64'(a_over), 64'h0);
        chk("rst_a_bus",  a_bus,       64'h0);
        chk("rst_b_addr", 64'(b_addr), 64'h0000_1000);

        // ---------------- instance a, ROM_LAT=1 ----------------
        reset_a  = 1'b0;
        if_valid = 1'b1;
        step();                                   // IDLE->WAIT
        chk("a_lat_over0", 64'(a_over), 64'h0);
        step();                                   // capture
        chk("a_over1",  64'(a_over), 64'h1);
        chk("a_bus0",   a_bus, {32'h0, rom_f(32'h0)});
        chk("a_ifpc0",  64'(a_pc), 64'h0);
        chk("a_ifinst0", 64'(a_iinst), 64'(rom_f(32'h0)));
        step();                                   // DONE, IF_valid held
        chk("a_over_single", 64'(a_over), 64'h0);

        next_fetch = 1'b1;
        step(); step(); step(); step();
        chk("a_pc10",      64'(a_addr), 64'h10);
        chk("a_bus_hold",  a_bus, {32'h0, rom_f(32'h0)});
        step();
        chk("a_pc14",      64'(a_addr), 64'h14);
        chk("a_bus_hold2", a_bus, {32'h0, rom_f(32'h0)});
        next_fetch = 1'b0;

        if_valid = 1'b0; step();                  // DONE->IDLE
        if_valid = 1'b1; step();                  // IDLE->WAIT
        step();                                   // capture at 0x14
        chk("a_over2", 64'(a_over), 64'h1);
        chk("a_bus14", a_bus, {32'h14, rom_f(32'h14)});

        // Pending taken branch
        id_over = 1'b1; jbr_bus = {1'b1, 32'h0000_0100};
        step();
        id_over = 1'b0; jbr_bus = 33'd0;
        chk("a_pending_nomove", 64'(a_addr), 64'h14);
        next_fetch = 1'b1; step(); next_fetch = 1'b0;
        chk("a_br100", 64'(a_addr), 64'h100);
        next_fetch = 1'b1; step(); next_fetch = 1'b0;
        chk("a_br104", 64'(a_addr), 64'h104);

        // Not-taken report leaves pending state clear
        id_over = 1'b1; jbr_bus = {1'b0, 32'h0000_0300};
        step();
        id_over = 1'b0; jbr_bus = 33'd0;
        next_fetch = 1'b1; step(); next_fetch = 1'b0;
        chk("a_nt108", 64'(a_addr), 64'h108);

        // Simultaneous branch and advance
        id_over = 1'b1; jbr_bus = {1'b1, 32'h0000_0200}; next_fetch = 1'b1;
        step();
        id_over = 1'b0; jbr_bus = 33'd0;
        chk("a_sim200", 64'(a_addr), 64'h200);
        step();                                   // next_fetch still high
        next_fetch = 1'b0;
        chk("a_sim204", 64'(a_addr), 64'h204);

        // Unaligned target used as given
        id_over = 1'b1; jbr_bus = {1'b1, 32'h0000_0203}; next_fetch = 1'b1;
        step();
        id_over = 1'b0; jbr_bus = 33'd0;
        chk("a_unal203", 64'(a_addr), 64'h203);
        step();
        next_fetch = 1'b0;
        chk("a_unal207", 64'(a_addr), 64'h207);

        // Wrap at the top of the address space
        id_over = 1'b1; jbr_bus = {1'b1, 32'hFFFF_FFFC}; next_fetch = 1'b1;
        step();
        id_over = 1'b0; jbr_bus = 33'd0;
        chk("a_top", 64'(a_addr), 64'hFFFF_FFFC);
        step();
        next_fetch = 1'b0;
        chk("a_wrap", 64'(a_addr), 64'h0);

        // next_fetch arriving while in WAIT is ignored
        if_valid = 1'b0; step();                  // IDLE
        if_valid = 1'b1; step();                  // WAIT
        next_fetch = 1'b1; step(); next_fetch = 1'b0;   // capture edge
        chk("a_wait_ign_pc", 64'(a_addr), 64'h0);
        chk("a_wait_over",   64'(a_over), 64'h1);
        chk("a_wait_bus",    a_bus, {32'h0, rom_f(32'h0)});

        // ---------------- instance b, ROM_LAT=4 ----------------
        if_valid = 1'b0;
        reset_b  = 1'b0;
        next_fetch = 1'b1; step(); step(); next_fetch = 1'b0;
        chk("b_pc1008", 64'(b_addr), 64'h1008);

        if_valid = 1'b1;
        step();                                   // IDLE->WAIT, cnt=3
        chk("b_w0_over", 64'(b_over), 64'h0);
        // Advance ignored in WAIT while a branch is recorded as pending
        next_fetch = 1'b1; id_over = 1'b1; jbr_bus = {1'b1, 32'h0000_0500};
        step();                                   // cnt=2
        next_fetch = 1'b0; id_over = 1'b0; jbr_bus = 33'd0;
        chk("b_wait_ign", 64'(b_addr), 64'h1008);
        chk("b_w1_over",  64'(b_over), 64'h0);
        step();                                   // cnt=1
        chk("b_w2_over",  64'(b_over), 64'h0);

        reset_b = 1'b1;
        #1;
        chk("b_async_pc",   64'(b_addr), 64'h1000);
        chk("b_async_over", 64'(b_over), 64'h0);
        step();
        chk("b_rst_over", 64'(b_over), 64'h0);
        chk("b_rst_bus",  b_bus, 64'h0);
        reset_b = 1'b0;                           // IF_valid still 1

        step();                                   // IDLE->WAIT
        chk("b_r0_over", 64'(b_over), 64'h0);
        step();
        chk("b_r1_over", 64'(b_over), 64'h0);
        step();
        chk("b_r2_over", 64'(b_over), 64'h0);
        step();
        chk("b_r3_over", 64'(b_over), 64'h0);
        step();                                   // fourth edge after WAIT entry
        chk("b_lat4_over", 64'(b_over), 64'h1);
        chk("b_lat4_bus",  b_bus, {32'h0000_1000, rom_f(32'h0000_1000)});
        step();
        chk("b_over_single", 64'(b_over), 64'h0);

        // Pending branch was cleared by reset
        if_valid = 1'b0; step();
        next_fetch = 1'b1; step(); next_fetch = 1'b0;
        chk("b_no_pending", 64'(b_addr), 64'h1004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
